// File: rtl/draw_card_ctrl_pkg.sv
// Shared board geometry, card codes, hand-field addressing and state encoding
// for the hand-draw controller.
package draw_card_ctrl_pkg;

  localparam int ROWS       = 8;
  localparam int COLS       = 18;
  localparam int CODE_W     = 6;
  localparam int MAP_BITS   = ROWS * COLS * CODE_W;
  localparam int HAND_SLOTS = 36;
  localparam int HAND_BASE  = MAP_BITS - HAND_SLOTS * CODE_W;

  localparam logic [5:0]        LAST_SLOT = 6'(HAND_SLOTS - 1);
  localparam logic [CODE_W-1:0] NO_CARD   = 6'd54;
  localparam logic [6:0]        DECK_SIZE = 7'd106;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_SCAN  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_FAIL  = 3'd6
  } state_t;

  // Hand position 0 is the lowest field of the hand region; 35 is the map MSBs.
  function automatic int hand_lsb(input int p);
    return HAND_BASE + p * CODE_W;
  endfunction

endpackage

// File: rtl/draw_card_ctrl_hand_slot_mux.sv
// Combinational 36:1 selector returning the 6-bit hand field at pos.
// Out-of-range positions read as code 0 (occupied), so they never look empty.
module hand_slot_mux
  import draw_card_ctrl_pkg::*;
(
  input  logic [MAP_BITS-1:0] map,
  input  logic [5:0]          pos,
  output logic [CODE_W-1:0]   field
);

  // Only the hand region is decoded; the rest of the map is folded into a sink.
  logic unused_low_map;
  assign unused_low_map = ^map[HAND_BASE-1:0];

  always_comb begin
    field = '0;
    for (int p = 0; p < HAND_SLOTS; p++) begin
      if (pos == 6'(p)) begin
        field = map[hand_lsb(p) +: CODE_W];
      end
    end
  end

endmodule

// File: rtl/draw_card_ctrl.sv
// Draws 1-3 deck cards into the lowest empty hand slots, one map write per card.
// A card is consumed only when written; the scan resumes after the last written slot.
module draw_card_ctrl
  import draw_card_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                interboard_rst,
  input  logic                draw_req,
  input  logic [1:0]          draw_num,
  input  logic [MAP_BITS-1:0] map,
  output logic [6:0]          deck_addr,
  input  logic [5:0]          deck_card,
  output logic                wr_en,
  output logic [5:0]          wr_pos,
  output logic [5:0]          wr_card,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [1:0]          placed,
  output logic [6:0]          deck_remain
);

  state_t      state_q, state_d;
  logic [6:0]  deck_ptr_q, deck_ptr_d;
  logic [5:0]  scan_pos_q, scan_pos_d;
  logic [1:0]  remaining_q, remaining_d;
  logic [1:0]  placed_q, placed_d;
  logic [5:0]  card_reg_q, card_reg_d;
  logic        wr_en_q, wr_en_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;
  logic        busy_q, busy_d;
  logic [5:0]  field;

  hand_slot_mux u_hand_slot_mux (
    .map   (map),
    .pos   (scan_pos_q),
    .field (field)
  );

  always_comb begin
    state_d     = state_q;
    deck_ptr_d  = deck_ptr_q;
    scan_pos_d  = scan_pos_q;
    remaining_d = remaining_q;
    placed_d    = placed_q;
    card_reg_d  = card_reg_q;

    case (state_q)
      S_IDLE: begin
        if (draw_req) begin
          remaining_d = (draw_num == 2'd0) ? 2'd1 : draw_num;
          scan_pos_d  = '0;
          placed_d    = '0;
          state_d     = (deck_ptr_q == DECK_SIZE) ? S_FAIL : S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        card_reg_d = deck_card;
        state_d    = S_SCAN;
      end
      S_SCAN: begin
        if (field == NO_CARD) begin
          state_d = S_WRITE;
        end else if (scan_pos_q == LAST_SLOT) begin
          state_d = S_FAIL;
        end else begin
          scan_pos_d = scan_pos_q + 6'd1;
        end
      end
      S_WRITE: begin
        deck_ptr_d  = (deck_ptr_q == DECK_SIZE) ? deck_ptr_q : deck_ptr_q + 7'd1;
        placed_d    = placed_q + 2'd1;
        remaining_d = remaining_q - 2'd1;
        scan_pos_d  = scan_pos_q + 6'd1;
        // Completion wins over deck/hand exhaustion when the last card lands.
        if (remaining_q == 2'd1) begin
          state_d = S_DONE;
        end else if ((deck_ptr_q + 7'd1 == DECK_SIZE) || (scan_pos_q == LAST_SLOT)) begin
          state_d = S_FAIL;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    wr_en_d = (state_d == S_WRITE);
    done_d  = (state_d == S_DONE);
    fail_d  = (state_d == S_FAIL);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst || interboard_rst) begin
      state_q     <= S_IDLE;
      deck_ptr_q  <= '0;
      scan_pos_q  <= '0;
      remaining_q <= '0;
      placed_q    <= '0;
      card_reg_q  <= '0;
      wr_en_q     <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      deck_ptr_q  <= deck_ptr_d;
      scan_pos_q  <= scan_pos_d;
      remaining_q <= remaining_d;
      placed_q    <= placed_d;
      card_reg_q  <= card_reg_d;
      wr_en_q     <= wr_en_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      busy_q      <= busy_d;
    end
  end

  assign deck_addr   = deck_ptr_q;
  assign deck_remain = DECK_SIZE - deck_ptr_q;
  assign wr_en       = wr_en_q;
  assign wr_pos      = scan_pos_q;
  assign wr_card     = card_reg_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign placed      = placed_q;

endmodule

// File: tb/tb_draw_card_ctrl.sv
// Bench for draw_card_ctrl: table of single draws, deck exhaustion, peer reset, busy re-request.
module tb_draw_card_ctrl;

  localparam int MAP_W = 864;
  localparam int NOC   = 54;
  localparam int DECK  = 106;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             interboard_rst = 1'b0;
  logic             draw_req = 1'b0;
  logic [1:0]       draw_num = 2'd0;
  logic [MAP_W-1:0] map = '0;
  logic [6:0]       deck_addr;
  logic [5:0]       deck_card;
  logic             wr_en;
  logic [5:0]       wr_pos;
  logic [5:0]       wr_card;
  logic             busy;
  logic             done;
  logic             fail;
  logic [1:0]       placed;
  logic [6:0]       deck_remain;

  draw_card_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .interboard_rst (interboard_rst),
    .draw_req       (draw_req),
    .draw_num       (draw_num),
    .map            (map),
    .deck_addr      (deck_addr),
    .deck_card      (deck_card),
    .wr_en          (wr_en),
    .wr_pos         (wr_pos),
    .wr_card        (wr_card),
    .busy           (busy),
    .done           (done),
    .fail           (fail),
    .placed         (placed),
    .deck_remain    (deck_remain)
  );

  always #5 clk = ~clk;

  logic [5:0] deck_mem [0:127];
  always @(posedge clk) deck_card <= deck_mem[deck_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct { int pos; int card; } wr_t;
  typedef struct { int is_fail; int placed; int remain; } end_t;
  wr_t  wr_q[$];
  end_t end_q[$];

  task automatic push_wr(input int pos, input int card);
    wr_t w;
    w.pos = pos; w.card = card;
    wr_q.push_back(w);
  endtask

  task automatic push_end(input int is_fail, input int plc, input int remain);
    end_t e;
    e.is_fail = is_fail; e.placed = plc; e.remain = remain;
    end_q.push_back(e);
  endtask

  // Scoreboard: every write and every done/fail pulse must match the next expectation.
  always @(negedge clk) begin
    wr_t  w;
    end_t e;
    if (wr_en) begin
      if (wr_q.size() == 0) chk("unexpected_wr", 1, 0);
      else begin
        w = wr_q.pop_front();
        chk("wr_pos", int'(wr_pos), w.pos);
        chk("wr_card", int'(wr_card), w.card);
      end
    end
    if (done || fail) begin
      if (end_q.size() == 0) chk("unexpected_end", 1, 0);
      else begin
        e = end_q.pop_front();
        chk("end_fail", int'(fail), e.is_fail);
        chk("end_done", int'(done), 1 - e.is_fail);
        chk("end_placed", int'(placed), e.placed);
        chk("end_deck_remain", int'(deck_remain), e.remain);
      end
    end
  end

  // Occupied slots hold code p+1; empty slots and everything outside the hand hold NO_CARD.
  function automatic logic [MAP_W-1:0] build_map(input logic [35:0] occ);
    logic [MAP_W-1:0] m;
    for (int i = 0; i < MAP_W / 6; i++) m[i*6 +: 6] = 6'(NOC);
    for (int p = 0; p < 36; p++)
      m[MAP_W-1-(35-p)*6 -: 6] = occ[p] ? 6'(p + 1) : 6'(NOC);
    return m;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one draw; cycle 1 is the first cycle after the request is sampled.
  task automatic run_draw(input logic [1:0] n, input int exp_first, input int exp_end);
    int c;
    int first;
    int fin;
    draw_num = n;
    draw_req = 1'b1;
    @(negedge clk);
    draw_req = 1'b0;
    chk("busy_after_req", int'(busy), 1);
    c = 1; first = -1; fin = 0;
    while (fin == 0 && c < 300) begin
      if (wr_en && first < 0) first = c;
      if (done || fail) fin = 1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    chk("draw_finished", fin, 1);
    chk("first_wr_cycle", first, exp_first);
    chk("end_cycle", c, exp_end);
    @(negedge clk);
    chk("idle_after_draw", int'(busy), 0);
  endtask

  typedef struct {
    logic [1:0]  num;
    logic [35:0] occ;
    int c0, c1, c2;
    int nwr;
    int p0, p1, p2;
    int is_fail;
    int first;
    int fin;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int c;
    vecs[0] = '{num: 2'd1, occ: 36'h0,         c0: 12, c1: 0,  c2: 0,  nwr: 1, p0: 0,  p1: 0,  p2: 0,  is_fail: 0, first: 4,  fin: 5};
    vecs[1] = '{num: 2'd2, occ: 36'h05F,       c0: 3,  c1: 40, c2: 0,  nwr: 2, p0: 5,  p1: 7,  p2: 0,  is_fail: 0, first: 9,  fin: 15};
    vecs[2] = '{num: 2'd1, occ: 36'hFFFFFFFFF, c0: 9,  c1: 0,  c2: 0,  nwr: 0, p0: 0,  p1: 0,  p2: 0,  is_fail: 1, first: -1, fin: 39};
    vecs[3] = '{num: 2'd0, occ: 36'h0,         c0: 7,  c1: 8,  c2: 0,  nwr: 1, p0: 0,  p1: 0,  p2: 0,  is_fail: 0, first: 4,  fin: 5};
    vecs[4] = '{num: 2'd3, occ: 36'h7FFFFFBFF, c0: 20, c1: 21, c2: 22, nwr: 2, p0: 10, p1: 35, p2: 0,  is_fail: 1, first: 14, fin: 43};
    vecs[5] = '{num: 2'd3, occ: 36'h1FFFFFFFF, c0: 50, c1: 51, c2: 53, nwr: 3, p0: 33, p1: 34, p2: 35, is_fail: 0, first: 37, fin: 46};
    vecs[6] = '{num: 2'd2, occ: 36'hBFFFFFFFF, c0: 1,  c1: 2,  c2: 0,  nwr: 1, p0: 34, p1: 0,  p2: 0,  is_fail: 1, first: 38, fin: 42};
    vecs[7] = '{num: 2'd3, occ: 36'h0,         c0: 0,  c1: 17, c2: 45, nwr: 3, p0: 0,  p1: 1,  p2: 2,  is_fail: 0, first: 4,  fin: 13};

    for (int i = 0; i < 128; i++) deck_mem[i] = 6'd0;
    @(negedge clk);
    do_reset();
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_placed", int'(placed), 0);
    chk("rst_deck_remain", int'(deck_remain), DECK);
    chk("rst_deck_addr", int'(deck_addr), 0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      deck_mem[0] = 6'(vecs[i].c0);
      deck_mem[1] = 6'(vecs[i].c1);
      deck_mem[2] = 6'(vecs[i].c2);
      map = build_map(vecs[i].occ);
      if (vecs[i].nwr > 0) push_wr(vecs[i].p0, vecs[i].c0);
      if (vecs[i].nwr > 1) push_wr(vecs[i].p1, vecs[i].c1);
      if (vecs[i].nwr > 2) push_wr(vecs[i].p2, vecs[i].c2);
      push_end(vecs[i].is_fail, vecs[i].nwr, DECK - vecs[i].nwr);
      run_draw(vecs[i].num, vecs[i].first, vecs[i].fin);
    end

    // Deck exhaustion: 105 cards drawn in threes, then a draw that runs dry, then an empty deck.
    do_reset();
    for (int i = 0; i < DECK; i++) deck_mem[i] = 6'(i % NOC);
    map = build_map(36'h0);
    for (int k = 0; k < 35; k++) begin
      for (int j = 0; j < 3; j++) push_wr(j, (3 * k + j) % NOC);
      push_end(0, 3, DECK - 3 * (k + 1));
      run_draw(2'd3, 4, 13);
    end
    push_wr(0, 105 % NOC);
    push_end(1, 1, 0);
    run_draw(2'd3, 4, 5);
    push_end(1, 0, 0);
    run_draw(2'd1, -1, 1);

    // Peer reset while scanning a 3-card draw.
    do_reset();
    deck_mem[0] = 6'd31;
    map = build_map(36'hFBFFFFFFF);
    push_wr(30, 31);
    push_end(0, 1, DECK - 1);
    run_draw(2'd1, 34, 35);
    draw_num = 2'd3;
    draw_req = 1'b1;
    @(negedge clk);
    draw_req = 1'b0;
    repeat (5) @(negedge clk);
    interboard_rst = 1'b1;
    @(negedge clk);
    interboard_rst = 1'b0;
    chk("ibrst_busy", int'(busy), 0);
    chk("ibrst_wr_en", int'(wr_en), 0);
    chk("ibrst_deck_remain", int'(deck_remain), DECK);
    chk("ibrst_placed", int'(placed), 0);
    repeat (40) @(negedge clk);
    chk("ibrst_stays_idle", int'(busy), 0);

    // Second request while busy is dropped; draw_num 0 places exactly one card.
    do_reset();
    deck_mem[0] = 6'd33;
    deck_mem[1] = 6'd34;
    map = build_map(36'h0);
    push_wr(0, 33);
    push_end(0, 1, DECK - 1);
    draw_num = 2'd0;
    draw_req = 1'b1;
    @(negedge clk);
    draw_req = 1'b0;
    @(negedge clk);
    draw_num = 2'd3;
    draw_req = 1'b1;
    @(negedge clk);
    draw_req = 1'b0;
    c = 3;
    while (!(done || fail) && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("rereq_done", int'(done), 1);
    chk("rereq_end_cycle", c, 5);
    repeat (20) @(negedge clk);
    chk("rereq_idle", int'(busy), 0);
    chk("rereq_deck_remain", int'(deck_remain), DECK - 1);

    chk("wr_queue_drained", wr_q.size(), 0);
    chk("end_queue_drained", end_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/draw_card_ctrl.md
Name: draw_card_ctrl

Overview:
- Sequences drawing 1-3 cards from the deck into the local player's hand region of the 8x18 board map.
- Per card: reads the next deck entry from synchronous deck RAM, serially scans the 36 hand positions for the lowest empty position (code NO_CARD), then issues a one-cycle map write.
- Sits between the turn FSM, which issues draw_req, and the map register file, which owns the writes.

Parameters:
- HAND_SLOTS, 36, number of hand positions scanned (p = 0..HAND_SLOTS-1).
- NO_CARD, 54, card code marking an empty slot.
- DECK_SIZE, 106, number of cards in the deck RAM.
- MAP_BITS, 864, map width (8*18*6).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- interboard_rst  in  1  synchronous active-high reset from the peer board; same effect as rst
- draw_req  in  1  one-cycle start pulse; ignored unless busy=0
- draw_num  in  2  cards to draw; sampled with draw_req; 0 is treated as 1
- map  in  MAP_BITS  current board map; position p is the field map[MAP_BITS-1-(35-p)*6 -: 6]
- deck_addr  out  7  deck RAM read address (= deck_ptr)
- deck_card  in  6  deck RAM data, valid 1 cycle after deck_addr
- wr_en  out  1  map write strobe, one cycle
- wr_pos  out  6  hand position written (0..35)
- wr_card  out  6  card code written
- busy  out  1  high from the cycle after an accepted draw_req until done/fail
- done  out  1  one-cycle pulse: all requested cards placed
- fail  out  1  one-cycle pulse: hand full or deck exhausted
- placed  out  2  cards placed in the last operation; valid with done or fail
- deck_remain  out  7  DECK_SIZE - deck_ptr

Behaviour:
- Reset (rst or interboard_rst, any state, including mid-operation):
  - state=IDLE, deck_ptr=0, scan_pos=0, remaining=0, placed=0.
  - All strobes 0; busy=0; deck_remain=DECK_SIZE.
  - No partial write completes after reset.
- IDLE:
  - On draw_req, latch remaining = (draw_num==0 ? 1 : draw_num), set scan_pos=0, placed=0.
  - If deck_ptr==DECK_SIZE, go to FAIL; otherwise go to FETCH.
- FETCH (1 cycle): deck_addr=deck_ptr is presented; go to LATCH.
- LATCH (1 cycle): capture deck_card into card_reg; go to SCAN.
- SCAN (one position per cycle):
  - If field(scan_pos)==NO_CARD, go to WRITE.
  - Else, if scan_pos==HAND_SLOTS-1, go to FAIL.
  - Else, scan_pos++.
- WRITE (1 cycle):
  - Outputs: wr_en=1, wr_pos=scan_pos, wr_card=card_reg.
  - Updates: deck_ptr++, placed++, remaining--, scan_pos++. scan_pos resumes from p+1 rather than rescanning, so there is no dependency on map write-back latency.
  - If remaining becomes 0, go to DONE.
  - Else, if deck_ptr+1==DECK_SIZE or scan_pos==HAND_SLOTS-1, go to FAIL.
  - Else, go to FETCH.
- DONE: done=1 for 1 cycle; go to IDLE.
- FAIL: fail=1 for 1 cycle; go to IDLE. A deck card is consumed only when written; a hand-full fail does not advance deck_ptr.
- busy=1 in every state except IDLE.
- draw_req while busy is ignored; it is not queued.
- Latency, single card, empty slot at p: draw_req -> wr_en takes 3+p+1 cycles (FETCH, LATCH, p+1 SCAN cycles); done follows wr_en by 1 cycle.
- deck_ptr saturates at DECK_SIZE and never wraps. Only reset restores it.
- Cards never-drawn and the map outside the hand region are never read or written.
- Only registered state-machine outputs drive strobes. deck_addr is combinational from deck_ptr.

Decomposition:
- Shared game package holds:
  - NO_CARD=54, DECK_SIZE=106, HAND_SLOTS=36, map geometry (ROWS=8, COLS=18, CODE_W=6).
  - Hand-position-to-bit-offset function.
  - State encoding localparams (IDLE, FETCH, LATCH, SCAN, WRITE, DONE, FAIL).
- One natural sub-module, hand_slot_mux: a combinational 36:1 6-bit field selector from map by scan_pos. The FSM and counters stay in draw_card_ctrl.

Test Plan:
- Reset, then empty hand (all 36 positions = 54), deck RAM[0]=12, draw_num=1 -> wr_en at cycle 4 with wr_pos=0, wr_card=12; done next cycle; placed=1; deck_remain=105.
- Positions 0..4 occupied, 5 empty, 6 occupied, 7 empty; deck[0..1]=3,40; draw_num=2 -> writes (pos 5, card 3) then (pos 7, card 40); done; placed=2; deck_remain=104.
- All 36 positions occupied, draw_num=1 -> no wr_en; fail after 36 SCAN cycles; placed=0; deck_remain unchanged.
- deck_ptr preloaded via 105 prior draws (deck_remain=1), draw_num=3 with empty hand -> one write; fail; placed=1; deck_remain=0. A further draw_req -> fail 1 cycle after IDLE, no write.
- interboard_rst asserted during SCAN of a 3-card draw -> next cycle busy=0, no wr_en, deck_remain=106.
- draw_req pulsed again while busy, draw_num=0 -> second request ignored; first completes with exactly 1 write (draw_num 0 treated as 1).
